// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler sharing one transmit word path among four VC queues.
// Each VC may send up to its programmed weight of consecutive words per turn.
module wrr_vc_scheduler #(
    parameter int DATA_W   = 4,
    parameter int WEIGHT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  edit_weight,
    input  logic [1:0]            vc_assign,
    input  logic [WEIGHT_W-1:0]   weight_assign,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   vc_data,
    output logic [3:0]            pop,
    output logic [DATA_W-1:0]     Data_Word,
    output logic                  data_valid,
    output logic [1:0]            gnt_vc,
    output logic                  busy
);

    // Handshake: req[i] is the queue's valid (head word present), pop[i] is our
    // ready; a word transfers on every rising edge where both are high.

    typedef enum logic {IDLE, SERVE} state_t;

    state_t              state;
    logic [WEIGHT_W-1:0] w [4];
    logic [1:0]          cur;
    logic [1:0]          ptr;
    logic [WEIGHT_W-1:0] cnt;
    logic [WEIGHT_W-1:0] cur_w;

    logic [DATA_W-1:0]   head [4];
    logic [3:0]          elig;
    logic [1:0]          base;
    logic [1:0]          idx;
    logic [1:0]          next_vc;
    logic                found;
    logic                turn_end;

    for (genvar g = 0; g < 4; g++) begin : g_vc
        assign head[g] = vc_data[g*DATA_W +: DATA_W];
        assign elig[g] = req[g] && (w[g] != '0);
    end

    // At turn end the search starts one past cur, so cur is naturally considered last.
    assign base = (state == SERVE) ? cur + 2'd1 : ptr;

    always_comb begin
        found   = 1'b0;
        next_vc = base;
        idx     = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (elig[idx]) begin
                found   = 1'b1;
                next_vc = idx;
            end
        end
    end

    always_comb begin
        pop = 4'b0000;
        if (reset && state == SERVE) begin
            pop[cur] = req[cur];
        end
    end

    assign turn_end = (state == SERVE) &&
                      (!req[cur] || (cnt == cur_w - WEIGHT_W'(1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cur        <= 2'd0;
            ptr        <= 2'd0;
            cnt        <= '0;
            cur_w      <= '0;
            Data_Word  <= '0;
            data_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                w[i] <= WEIGHT_W'(1);
            end
        end else begin
            // New turns latch the pre-write weight; the write lands on this same edge.
            if (edit_weight) begin
                w[vc_assign] <= weight_assign;
            end
            data_valid <= |pop;
            if (|pop) begin
                Data_Word <= head[cur];
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= SERVE;
                        cur   <= next_vc;
                        cnt   <= '0;
                        cur_w <= w[next_vc];
                    end
                end
                SERVE: begin
                    if (turn_end) begin
                        ptr <= cur + 2'd1;
                        if (found) begin
                            cur   <= next_vc;
                            cnt   <= '0;
                            cur_w <= w[next_vc];
                        end else begin
                            state <= IDLE;
                        end
                    end else if (pop[cur]) begin
                        cnt <= cnt + WEIGHT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_vc = cur;
    assign busy   = (state == SERVE);

endmodule

// File: doc/wrr_vc_scheduler.md
# wrr_vc_scheduler

Weighted round-robin scheduler that shares the single PCIe transmit word path among four virtual-channel (VC) queues. Each VC has a programmable weight: the maximum number of consecutive words it may send per turn. The block pops words from the VC queues and drives one registered output word per cycle. Weights are loaded through the same `edit_weight` / `vc_assign` / `weight_assign` configuration port the WRR bench drives.

## Interface

Parameters:
- `DATA_W`, default 4: width of one data word (`Data_Word`).
- `WEIGHT_W`, default 3: width of each weight and of the turn counter. Maximum weight is 7.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `edit_weight`, input, 1: when high at a clock edge, `weight_assign` is written to the weight register selected by `vc_assign`.
- `vc_assign`, input, 2: VC index for a weight write.
- `weight_assign`, input, WEIGHT_W: new weight value. A value of 0 disables that VC.
- `req`, input, 4: `req[i]` is high while VC i's queue holds at least one word (first-word-fall-through).
- `vc_data`, input, 4*DATA_W: head words; VC i occupies bits `[i*DATA_W +: DATA_W]`.
- `pop`, output, 4: one-hot or zero, combinational; the queue advances on an edge where `pop[i]` is high.
- `Data_Word`, output, DATA_W: registered word taken from the popped VC.
- `data_valid`, output, 1: registered; `Data_Word` is valid.
- `gnt_vc`, output, 2: registered index of the VC currently granted.
- `busy`, output, 1: high while in the SERVE state.

## Operation

- **State:**
  - Weights `w[0..3]`, reset value 1.
  - FSM state IDLE/SERVE, reset value IDLE.
  - `cur` (drives `gnt_vc`), reset value 0.
  - `ptr`, reset value 0.
  - `cnt`, reset value 0.
  - `cur_w`, reset value 0.
- **Eligibility:** `elig = req & {w[i] != 0}`. The next VC is the first set bit of `elig` searching `ptr`, `ptr+1`, … with mod-4 wrap.
- **IDLE:**
  - `pop = 0`.
  - If `elig != 0`: load `cur` = next VC, `cnt = 0`, `cur_w = w[cur]`, go to SERVE.
  - Otherwise stay in IDLE.
- **SERVE:**
  - `pop[cur] = req[cur]`.
  - On each edge where `pop[cur]` is high, `cnt` increments.
  - A turn ends when either:
    - (a) `pop[cur]` is high and `cnt == cur_w - 1`, or
    - (b) `req[cur]` is low, which is a wasted cycle with no pop.
  - At turn end: set `ptr = cur + 1` (mod 4), then search `elig`, sampled in the same cycle.
    - `cur` itself is considered last, so a VC that is the only requester is re-granted with `cnt = 0`.
    - If none are eligible, go to IDLE.
- **Output register:**
  - `Data_Word <= vc_data` slice of `cur` when `|pop`; otherwise it holds its value.
  - `data_valid <= |pop`.
- **Weight edits:**
  - A write takes effect from the next turn start. The current turn keeps using the latched `cur_w`.
  - Writing 0 to the VC being served does not cut its current turn short.
  - Simultaneous edit and turn-end on the same VC: the new turn latches the old weight. The write lands on the same edge.
- **All weights 0:** the block remains in IDLE with `pop = 0` regardless of `req`.
- **Reset:**
  - When `reset` is low at an edge, all registers return to their reset values.
  - `Data_Word = 0`, `data_valid = 0`, `gnt_vc = 0`, `busy = 0`.
  - `pop` is forced to 0 while `reset` is low.
  - A reset in the middle of a turn abandons the turn; no partial state survives.

## Timing

- IDLE → first pop: `req` high in cycle N gives SERVE and `pop` in cycle N+1.
- `pop` in cycle k gives `Data_Word` / `data_valid` in cycle k+1.
- Back-to-back turns have no bubble: the last pop of VC A in cycle k is followed by the first pop of VC B in cycle k+1, provided `req[B]` is high.
- A turn ended by a dropped `req` costs exactly one pop-free cycle.
- Throughput is one word per cycle while any eligible VC has data.
- `cnt` never exceeds `cur_w - 1`. The weight range is 1..7 and needs no saturation.

## Test plan

- **Reset defaults:** reset low for 2 cycles, then high; `req = 4'b1111` held. Required: `pop` cycles 0001, 0010, 0100, 1000, repeating; `data_valid` high from the second SERVE cycle onward.
- **Weighted pattern:** program weights VC0=3, VC1=1, VC2=2, VC3=0; `req = 4'b1111`. Required: pop sequence VC0 ×3, VC1 ×1, VC2 ×2, repeating; `pop[3]` never high.
- **Early termination:** VC0 weight 5, with `req[0]` dropping after 2 pops; `req[1]` high. Required: 2 pops of VC0, then one cycle with `pop = 0`, then `pop = 4'b0010`.
- **Mid-turn edit:** VC0 weight 4, and the weight is written to 1 after its first pop. Required: 4 pops in the current turn, 1 pop in the next VC0 turn.
- **Data path:** VC2 head word = 4'hA, other VCs hold distinct values. Required: `Data_Word = 4'hA` with `data_valid = 1` exactly one cycle after each `pop[2]`.
- **Reset mid-turn:** reset asserted during VC1's second pop of weight 3. Required:
  - `pop = 0` immediately.
  - Next cycle: `data_valid = 0`, `gnt_vc = 0`, all weights = 1.
  - After release, service restarts at VC0.
